condicionador_botoes: RTL and testbench

- Upstream input stage of the game datapath. It conditions the 7 raw push-buttons and produces the clean one-hot `botoes` vector that the datapath consumes.
- Each button is synchronised to the clock and debounced.
- A lock FSM then guarantees that at most one button is reported at a time, and that each physical press is reported as one clean high interval.
- It also provides a one-cycle press pulse and debug taps.

---
 rtl/condicionador_botoes_pkg.sv | 19 +
 rtl/condicionador_botoes_if.sv | 30 +++
 rtl/condicionador_botoes_debounce_1bit.sv | 39 +++
 rtl/condicionador_botoes.sv | 73 +++++++
 tb/tb_condicionador_botoes.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/condicionador_botoes_pkg.sv
// Shared types and constants for the button conditioning stage and the game datapath.
package condicionador_botoes_pkg;

  localparam int unsigned N_BOTOES = 7;
  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 20;
  localparam int unsigned CW_PADRAO = 5;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    TRAVADO   = 2'b01,
    LIBERANDO = 2'b10
  } estado_t;

  // Isolates the lowest set bit; index 0 has the highest priority.
  function automatic logic [N_BOTOES-1:0] menor_bit(input logic [N_BOTOES-1:0] v);
    return v & (~v + N_BOTOES'(1));
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-side bus: raw levels and enable in, clean one-hot vector and debug taps out.
interface condicionador_botoes_if;
  import condicionador_botoes_pkg::*;

  logic                habilita;
  logic [N_BOTOES-1:0] botoes_raw;
  logic [N_BOTOES-1:0] botoes;
  logic                tem_pressao;
  logic [1:0]          db_estado;
  logic [N_BOTOES-1:0] db_botoes_estaveis;

  modport master (
    output habilita,
    output botoes_raw,
    input  botoes,
    input  tem_pressao,
    input  db_estado,
    input  db_botoes_estaveis
  );

  modport slave (
    input  habilita,
    input  botoes_raw,
    output botoes,
    output tem_pressao,
    output db_estado,
    output db_botoes_estaveis
  );

endinterface

// File: rtl/condicionador_botoes_debounce_1bit.sv
// One button: two-flop synchroniser followed by a counter-based debouncer.
module debounce_1bit #(
  parameter int unsigned DEBOUNCE_CICLOS = 20,
  parameter int unsigned CW              = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic est
);

  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CICLOS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      est <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any sample agreeing with the stable level restarts the count.
      if (s2 == est) begin
        cnt <= '0;
      end else if (cnt == CntMax) begin
        est <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions raw push-buttons into a clean one-hot vector, one press reported at a time.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned CW              = CW_PADRAO
) (
  input logic                        clock,
  input logic                        reset,
  condicionador_botoes_if.slave      bus
);

  logic [N_BOTOES-1:0] est;
  logic [N_BOTOES-1:0] botoes_q;
  logic                tem_pressao_q;
  estado_t             estado_q;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_db
    debounce_1bit #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
      .CW             (CW)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (bus.botoes_raw[i]),
      .est  (est[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      botoes_q      <= '0;
      tem_pressao_q <= 1'b0;
    end else begin
      tem_pressao_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (bus.habilita && (est != '0)) begin
            botoes_q      <= menor_bit(est);
            tem_pressao_q <= 1'b1;
            estado_q      <= TRAVADO;
          end else begin
            botoes_q <= '0;
          end
        end
        TRAVADO: begin
          // botoes_q holds the locked one-hot; only that button's release matters.
          if ((est & botoes_q) == '0) begin
            botoes_q <= '0;
            estado_q <= LIBERANDO;
          end
        end
        LIBERANDO: begin
          botoes_q <= '0;
          if (est == '0) begin
            estado_q <= OCIOSO;
          end
        end
        default: begin
          botoes_q <= '0;
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.botoes             = botoes_q;
  assign bus.tem_pressao        = tem_pressao_q;
  assign bus.db_estado          = estado_q;
  assign bus.db_botoes_estaveis = est;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with default parameters (DEBOUNCE_CICLOS=20).
module tb_condicionador_botoes;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   p0;

  condicionador_botoes_if bus ();

  condicionador_botoes dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances n edges, sampling 1 time unit after each and counting press pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (bus.tem_pressao === 1'b1) pulses++;
    end
  endtask

  task automatic check_out(input string tag, input logic [6:0] b, input logic t,
                           input logic [1:0] e);
    check({tag, "_botoes"}, 32'(bus.botoes), 32'(b));
    check({tag, "_pulso"}, 32'(bus.tem_pressao), 32'(t));
    check({tag, "_estado"}, 32'(bus.db_estado), 32'(e));
  endtask

  initial begin
    bus.habilita   = 1'b1;
    bus.botoes_raw = 7'h7f;

    // Reset with every raw input pressed.
    tick(1);
    check_out("rst1", 7'b0, 1'b0, 2'b00);
    check("rst1_est", 32'(bus.db_botoes_estaveis), 32'h0);
    tick(1);
    check_out("rst2", 7'b0, 1'b0, 2'b00);
    reset          = 1'b0;
    bus.botoes_raw = 7'b0;
    tick(1);
    check_out("rst_after", 7'b0, 1'b0, 2'b00);
    check("rst_after_est", 32'(bus.db_botoes_estaveis), 32'h0);
    tick(5);

    // Clean press of button 3, held 50 cycles.
    bus.botoes_raw = 7'b0001000;
    tick(22);
    check_out("press_e22", 7'b0, 1'b0, 2'b00);
    check("press_e22_est", 32'(bus.db_botoes_estaveis), 32'h08);
    tick(1);
    check_out("press_e23", 7'b0001000, 1'b1, 2'b01);
    tick(1);
    check_out("press_e24", 7'b0001000, 1'b0, 2'b01);
    tick(26);
    bus.botoes_raw = 7'b0;
    tick(22);
    check_out("rel_e22", 7'b0001000, 1'b0, 2'b01);
    check("rel_e22_est", 32'(bus.db_botoes_estaveis), 32'h0);
    tick(1);
    check_out("rel_e23", 7'b0, 1'b0, 2'b10);
    tick(1);
    check_out("rel_e24", 7'b0, 1'b0, 2'b00);
    tick(5);

    // Bounce: 19 high, 1 low, five times on button 2.
    p0 = pulses;
    for (int r = 0; r < 5; r++) begin
      bus.botoes_raw = 7'b0000100;
      tick(19);
      bus.botoes_raw = 7'b0;
      tick(1);
    end
    tick(5);
    check("bounce_est", 32'(bus.db_botoes_estaveis), 32'h0);
    check_out("bounce", 7'b0, 1'b0, 2'b00);
    check("bounce_pulses", 32'(pulses - p0), 32'd0);
    // A 20-cycle pulse is just long enough.
    bus.botoes_raw = 7'b0000100;
    tick(20);
    bus.botoes_raw = 7'b0;
    tick(1);
    check("pulse20_e21_est", 32'(bus.db_botoes_estaveis), 32'h0);
    tick(1);
    check("pulse20_e22_est", 32'(bus.db_botoes_estaveis), 32'h04);
    tick(1);
    check_out("pulse20_e23", 7'b0000100, 1'b1, 2'b01);
    tick(25);
    check_out("pulse20_idle", 7'b0, 1'b0, 2'b00);
    tick(5);

    // Simultaneous press: lowest index wins.
    p0 = pulses;
    bus.botoes_raw = 7'b0100110;
    tick(23);
    check_out("simul_e23", 7'b0000010, 1'b1, 2'b01);
    check("simul_est", 32'(bus.db_botoes_estaveis), 32'h26);
    tick(10);
    bus.botoes_raw = 7'b0;
    tick(23);
    check_out("simul_rel", 7'b0, 1'b0, 2'b10);
    tick(1);
    check_out("simul_idle", 7'b0, 1'b0, 2'b00);
    check("simul_pulses", 32'(pulses - p0), 32'd1);
    tick(5);

    // Overlap: button 5 held across button 2's press is not reported.
    p0 = pulses;
    bus.botoes_raw = 7'b0000100;
    tick(23);
    check_out("ovl_b2", 7'b0000100, 1'b1, 2'b01);
    tick(5);
    bus.botoes_raw = 7'b0100100;
    tick(30);
    check_out("ovl_both", 7'b0000100, 1'b0, 2'b01);
    check("ovl_both_est", 32'(bus.db_botoes_estaveis), 32'h24);
    bus.botoes_raw = 7'b0100000;
    tick(23);
    check_out("ovl_rel2", 7'b0, 1'b0, 2'b10);
    tick(10);
    check_out("ovl_hold5", 7'b0, 1'b0, 2'b10);
    bus.botoes_raw = 7'b0;
    tick(22);
    check_out("ovl_rel5_e22", 7'b0, 1'b0, 2'b10);
    tick(1);
    check_out("ovl_rel5_e23", 7'b0, 1'b0, 2'b00);
    tick(5);
    check("ovl_pulses", 32'(pulses - p0), 32'd1);

    // habilita low blocks locking; raising it locks on the next edge.
    bus.habilita   = 1'b0;
    bus.botoes_raw = 7'b0000001;
    tick(30);
    check_out("hab0", 7'b0, 1'b0, 2'b00);
    check("hab0_est", 32'(bus.db_botoes_estaveis), 32'h01);
    bus.habilita = 1'b1;
    tick(1);
    check_out("hab1", 7'b0000001, 1'b1, 2'b01);
    tick(3);
    // Reset inside TRAVADO, button still held.
    reset = 1'b1;
    tick(1);
    check_out("rst_trav", 7'b0, 1'b0, 2'b00);
    check("rst_trav_est", 32'(bus.db_botoes_estaveis), 32'h0);
    reset = 1'b0;
    tick(22);
    check_out("rerep_e22", 7'b0, 1'b0, 2'b00);
    tick(1);
    check_out("rerep_e23", 7'b0000001, 1'b1, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
